// File: rtl/stream_bram.sv
// stream_bram: stream sink capturing 32-bit beats into bram_mem from address 0.
// At most one beat every two clocks; stalls when full unless wrap is enabled.
// Ports: clk, rst (sync, active-high), tdata/tvalid in, tready out (registered).
// Build option: define STREAM_BRAM_WRAP_EN to wrap the pointer instead of
// stalling when full (count saturates at DEPTH).
module stream_bram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tdata,
  input  logic                  tvalid,
  output logic                  tready
);

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] FULL =
    (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] bram_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  tready_q, tready_d;
  logic                  accept;

  assign accept = tvalid & tready_q;
  assign tready = tready_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (accept) begin
      wr_ptr_d = (wr_ptr_q == LAST) ?
        '0 : wr_ptr_q + 1'b1;
`ifdef STREAM_BRAM_WRAP_EN
      if (count_q != FULL) begin
        count_d = count_q + 1'b1;
      end
`else
      count_d = count_q + 1'b1;
`endif
    end
  end

  // Ready drops for one cycle after every accept, which is what
  // keeps a source holding a beat for two clocks from writing twice.
  always_comb begin
    tready_d = 1'b1;
    if (accept) begin
      tready_d = 1'b0;
    end
`ifndef STREAM_BRAM_WRAP_EN
    else if (count_d == FULL) begin
      tready_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      tready_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      tready_q <= tready_d;
    end
  end

  // Contents survive reset; only the pointer is rewound.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      bram_mem[wr_ptr_q] <= tdata;
    end
  end

endmodule

// File: tb/tb_stream_bram.sv
// tb_stream_bram: randomized self-checking bench for stream_bram.
// Reference model tracks accepts, expected ready and memory image.
module tb_stream_bram;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  int checks;
  int fails;

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH];
  int            m_ptr;
  int            m_cnt;
  bit            m_ready;
  bit            m_acc;
  int            n_acc;

  stream_bram #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .ADDR_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tdata(tdata),
    .tvalid(tvalid),
    .tready(tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive, advance to the edge, apply the rules, settle.
  task automatic step(input bit v,
                      input logic [DW-1:0] d,
                      input bit r);
    rst    = r;
    tvalid = v;
    tdata  = d;
    @(posedge clk);
    m_acc = 1'b0;
    if (r) begin
      m_ptr   = 0;
      m_cnt   = 0;
      m_ready = 1'b0;
    end else begin
      if (v && m_ready) begin
        m_acc          = 1'b1;
        m_mem[m_ptr]   = d;
        m_known[m_ptr] = 1'b1;
        m_ptr          = (m_ptr + 1) % DEPTH;
        m_cnt          = m_cnt + 1;
        n_acc          = n_acc + 1;
      end
`ifdef STREAM_BRAM_WRAP_EN
      m_ready = !m_acc;
`else
      m_ready = !m_acc && (m_cnt < DEPTH);
`endif
    end
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    int idle;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, $urandom, 1'b1);
      checks++;
      if (tready !== 1'b0) begin
        fails++;
        $display("FAIL reset_tready cyc%0d got %b exp 0",
                 i, tready);
      end
    end
    step(1'b0, '0, 1'b0);
    checks++;
    if (tready !== 1'b1) begin
      fails++;
      $display("FAIL release_tready got %b exp 1", tready);
    end
    idle = $urandom_range(3, 8);
    for (int i = 0; i < idle; i++) begin
      step(1'b0, $urandom, 1'b0);
      checks++;
      if (tready !== 1'b1) begin
        fails++;
        $display("FAIL idle_tready cyc%0d got %b exp 1",
                 i, tready);
      end
    end
  endtask

  task automatic test_fill();
    int bubbles;
    do_reset();
    bubbles = 0;
    for (int b = 0; b < DEPTH; b++) begin
      for (int h = 0; h < 2; h++) begin
        step(1'b1, DW'(100 + b), 1'b0);
        checks++;
        if (tready !== m_ready) begin
          fails++;
          $display("FAIL fill_tready beat%0d h%0d got %b exp %b",
                   b, h, tready, m_ready);
        end
        if (h == 0 && tready === 1'b0) bubbles++;
      end
    end
    checks++;
    if (bubbles != DEPTH) begin
      fails++;
      $display("FAIL fill_bubbles got %0d exp %0d",
               bubbles, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (dut.bram_mem[i] !== DW'(100 + i)) begin
        fails++;
        $display("FAIL fill_mem[%0d] got %0d exp %0d",
                 i, dut.bram_mem[i], 100 + i);
      end
    end
  endtask

`ifndef STREAM_BRAM_WRAP_EN
  task automatic test_overflow();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, DW'(999), 1'b0);
      checks++;
      if (tready !== 1'b0) begin
        fails++;
        $display("FAIL ovf_tready cyc%0d got %b exp 0",
                 i, tready);
      end
    end
    checks++;
    if (dut.bram_mem[0] !== DW'(100)) begin
      fails++;
      $display("FAIL ovf_mem0 got %0d exp 100",
               dut.bram_mem[0]);
    end
  endtask
`endif

  task automatic send_beat(input logic [DW-1:0] d);
    int guard;
    guard = 0;
    while (!m_ready && guard < 4) begin
      step(1'b0, '0, 1'b0);
      guard++;
    end
    step(1'b1, d, 1'b0);
    step(1'b1, d, 1'b0);
  endtask

  task automatic test_reset_midstream();
    logic [DW-1:0] exp [5];
    do_reset();
    for (int b = 0; b < 5; b++) send_beat(DW'(100 + b));
    step(1'b1, DW'(777), 1'b1);
    checks++;
    if (tready !== 1'b0) begin
      fails++;
      $display("FAIL mid_rst_tready got %b exp 0", tready);
    end
    send_beat(DW'(200));
    send_beat(DW'(201));
    exp[0] = 200; exp[1] = 201;
    exp[2] = 102; exp[3] = 103; exp[4] = 104;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut.bram_mem[i] !== exp[i]) begin
        fails++;
        $display("FAIL mid_mem[%0d] got %0d exp %0d",
                 i, dut.bram_mem[i], exp[i]);
      end
    end
  endtask

  task automatic test_continuous();
    int start;
    int seen;
    do_reset();
    start = n_acc;
    seen  = 0;
    for (int c = 0; c < 40; c++) begin
      if (tready === 1'b1) seen++;
      step(1'b1, 32'hA5A5_A5A5, 1'b0);
      checks++;
      if (tready !== m_ready) begin
        fails++;
        $display("FAIL cont_tready cyc%0d got %b exp %b",
                 c, tready, m_ready);
      end
    end
    checks++;
`ifdef STREAM_BRAM_WRAP_EN
    if (seen != 20 || n_acc - start != 20) begin
`else
    if (seen != DEPTH || n_acc - start != DEPTH) begin
`endif
      fails++;
      $display("FAIL cont_accepts got %0d model %0d",
               seen, n_acc - start);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (dut.bram_mem[i] !== 32'hA5A5_A5A5) begin
        fails++;
        $display("FAIL cont_mem[%0d] got %h exp a5a5a5a5",
                 i, dut.bram_mem[i]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    for (int c = 0; c < 80; c++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'b0);
      checks++;
      if (tready !== m_ready) begin
        fails++;
        $display("FAIL rnd_tready cyc%0d got %b exp %b",
                 c, tready, m_ready);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m_known[i]) begin
        checks++;
        if (dut.bram_mem[i] !== m_mem[i]) begin
          fails++;
          $display("FAIL rnd_mem[%0d] got %h exp %h",
                   i, dut.bram_mem[i], m_mem[i]);
        end
      end
    end
  endtask

`ifdef STREAM_BRAM_WRAP_EN
  task automatic test_wrap();
    do_reset();
    for (int b = 0; b < DEPTH + 1; b++) begin
      for (int h = 0; h < 2; h++) begin
        step(1'b1, DW'(100 + b), 1'b0);
        checks++;
        if (tready !== (h == 1)) begin
          fails++;
          $display("FAIL wrap_tready beat%0d h%0d got %b exp %b",
                   b, h, tready, (h == 1));
        end
      end
    end
    checks++;
    if (dut.bram_mem[0] !== DW'(116)) begin
      fails++;
      $display("FAIL wrap_mem0 got %0d exp 116",
               dut.bram_mem[0]);
    end
    for (int i = 1; i < DEPTH; i++) begin
      checks++;
      if (dut.bram_mem[i] !== DW'(100 + i)) begin
        fails++;
        $display("FAIL wrap_mem[%0d] got %0d exp %0d",
                 i, dut.bram_mem[i], 100 + i);
      end
    end
  endtask
`endif

  initial begin
    checks  = 0;
    fails   = 0;
    m_ptr   = 0;
    m_cnt   = 0;
    m_ready = 1'b0;
    n_acc   = 0;
    rst     = 1'b1;
    tvalid  = 1'b0;
    tdata   = '0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    test_reset();
    test_fill();
`ifndef STREAM_BRAM_WRAP_EN
    test_overflow();
`endif
    test_reset_midstream();
    test_continuous();
    test_random();
`ifdef STREAM_BRAM_WRAP_EN
    test_wrap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/stream_bram.md
Name: stream_bram

Overview:
- AXI-Stream-style sink that writes incoming 32-bit beats into an internal memory array named bram_mem at sequential addresses starting from 0.
- Serves as the capture buffer at the end of the DMA stream path.
- Memory contents are inspected by benches through the hierarchical reference bram_mem[index].
- Rate-limited to at most one beat every two clocks, so a source holding tvalid/tdata for two cycles per beat is never double-written.

Parameters:
- DATA_WIDTH, 32: width of tdata and of each bram_mem word.
- DEPTH, 16: number of bram_mem entries.
- ADDR_WIDTH, 4: write pointer width; must satisfy 2**ADDR_WIDTH >= DEPTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- tdata  input  DATA_WIDTH  stream payload.
- tvalid  input  1  source asserts when tdata is valid.
- tready  output  1  sink ready (registered).

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Internal state:
  - bram_mem[0..DEPTH-1], DATA_WIDTH bits each, named exactly bram_mem.
  - wr_ptr, ADDR_WIDTH bits.
  - count, ADDR_WIDTH+1 bits, 0..DEPTH.
  - tready register.
- Reset (rst=1 at a rising edge):
  - wr_ptr=0, count=0, tready=0.
  - bram_mem is not cleared.
  - A beat presented during a reset cycle is discarded.
- Handshake: a beat is accepted on a rising edge where tvalid=1 and tready=1. At that same edge:
  - bram_mem[wr_ptr] <= tdata.
  - wr_ptr increments.
  - count increments.
  - Write latency is 0 cycles after the handshake edge.
- tready next-state, evaluated each edge with rst=0:
  - 0 if a beat was accepted this edge (mandatory one-cycle bubble after every accept).
  - Else 0 if count (post-update) == DEPTH.
  - Else 1.
- Consequences:
  - First cycle after reset deassertion: tready=1.
  - Maximum throughput is 1 beat per 2 clocks.
  - With tvalid held high, beats are accepted on alternate edges.
  - tready does not depend combinationally on tvalid.
- Idle: while tvalid=0, tready stays 1 (if not full) and no state changes.
- Full: after the DEPTH-th accepted beat, tready stays 0 indefinitely. Further tvalid has no effect; only rst recovers.
- Reset mid-stream: pointer and count return to 0. Already-written words remain in bram_mem until overwritten.
- tdata is sampled only on handshake edges; its value on other edges is don't-care.

Optional Feature:
- Macro: STREAM_BRAM_WRAP_EN.
- Defined:
  - The full condition is removed.
  - wr_ptr wraps from DEPTH-1 to 0 and subsequent beats overwrite the oldest words.
  - count saturates at DEPTH.
  - tready follows only the accept/bubble rule.
- Undefined (default): the stall-when-full behaviour above.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, tvalid=0 -> tready=0 during reset, tready=1 on the first edge after release, and stays 1 while idle.
- Sequential fill: 16 beats of tdata=100..115, each held with tvalid=1 for two clocks -> bram_mem[i]=100+i for i=0..15, no duplicates, tready low for exactly one cycle after each accept.
- Continuous tvalid with a constant tdata=0xA5A5A5A5 -> accepts on alternate edges only; after 16 accepts, count=16 and tready=0 permanently.
- Overflow attempt (macro undefined): after the 16-beat fill, present tdata=999 with tvalid=1 for 10 cycles -> tready stays 0 and bram_mem[0]=100 is unchanged.
- Reset mid-stream: after 5 beats (100..104), pulse rst, then send 200,201 -> bram_mem[0]=200, bram_mem[1]=201, bram_mem[2..4]=102..104 retained.
- Wrap (STREAM_BRAM_WRAP_EN defined): send 17 beats 100..116 -> bram_mem[0]=116, bram_mem[1..15]=101..115, tready never stalls beyond the one-cycle bubble.
